brg_cfg_ctrl: RTL
=================

Name: brg_cfg_ctrl

Overview:
Configuration sequencer for the baud rate generator (BRG). It accepts either a baud-table index or a raw 16-bit divisor. It then drives the BRG's byte-wide divisor write strobes: low byte first, high byte second. It confirms the new rate is live by counting en_16x pulses, then reports done or err to the requester. It sits between the host/control logic and the BRG, and is the only writer of the BRG divisor.

Parameters:
TIMEOUT, 140000, cycles allowed in SYNC for two en_16x pulses before err (covers max divisor 0xFFFF twice)
TO_W, 18, width of timeout counter; must hold TIMEOUT

Ports:
clk      input   1   system clock
rst_n    input   1   asynchronous active-low reset
sel_req  input   1   1-cycle request: load divisor from table entry sel_idx
sel_idx  input   3   baud table index
div_req  input   1   1-cycle request: load raw divisor div_val
div_val  input   16  raw divisor
en_16x   input   1   BRG reload pulse (feedback)
wr_dbl   output  1   BRG low-byte write strobe
wr_dbh   output  1   BRG high-byte write strobe
data_out output  8   BRG divisor byte bus
busy     output  1   high whenever state != IDLE
done     output  1   1-cycle pulse: new divisor confirmed active
err      output  1   1-cycle pulse: request rejected or timed out
locked   output  1   high while cur_div is confirmed active in BRG
cur_div  output  16  last confirmed divisor

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - wr_dbl = wr_dbh = 0; data_out = 0x00.
  - busy = done = err = 0.
  - cur_div = 0x0145 (matches BRG reset divisor).
  - locked = 1.
  - Pulse counter and timeout counter = 0.
- Baud table (50 MHz clk, divisor = clk/(16*baud) - 1):
  - 0: 0x028A (4800)
  - 1: 0x0145 (9600)
  - 2: 0x00A2 (19200)
  - 3: 0x0050 (38400)
  - 4: 0x0035 (57600)
  - 5: 0x001A (115200)
  - 6 and 7: invalid.
- Requests are sampled only in IDLE. Requests arriving when not IDLE are dropped silently; no queueing.
- If div_req and sel_req are high in the same cycle, div_req wins and sel_req is dropped.
- Rejection, evaluated in IDLE:
  - Condition: div_req with div_val == 0, or sel_req with sel_idx of 6 or 7.
  - Response: err pulses the next cycle, state stays IDLE, no BRG writes, cur_div and locked unchanged.
- Accepted request: latch the target divisor into pend_div, clear locked, go to WR_LO.
- States:
  - IDLE: as above.
  - WR_LO (1 cycle): wr_dbl=1, data_out=pend_div[7:0]. Go to WR_HI.
  - WR_HI (1 cycle): wr_dbh=1, data_out=pend_div[15:8]. Clear pulse counter and timeout counter. Go to SYNC.
  - SYNC: count en_16x pulses and increment the timeout counter every cycle.
    - The first pulse is the reload that may still carry the old period. The second pulse marks the first full period at the new divisor.
    - On the 2nd pulse: next cycle done=1, cur_div=pend_div, locked=1, go to IDLE.
    - If the timeout counter reaches TIMEOUT first: next cycle err=1, locked stays 0, cur_div unchanged, go to IDLE.
  - An en_16x pulse in the same cycle as timeout expiry counts as success (pulse has priority).
- Strobes and data bus:
  - wr_dbl and wr_dbh are never high together.
  - data_out returns to 0x00 when neither strobe is high.
- Latency: request accepted in cycle N gives wr_dbl in N+1 and wr_dbh in N+2. done follows the 2nd en_16x pulse after N+2 by one cycle.
- en_16x pulses during IDLE, WR_LO and WR_HI are ignored.
- Writing the same divisor as cur_div is not special-cased; the full sequence runs.
- Reset mid-operation: all state returns to reset values immediately. A half-written BRG divisor is not repaired; the BRG is reset by the same rst_n.

Test Plan:
1. Reset, then sel_req with sel_idx=5 -> wr_dbl with data_out=0x1A in the next cycle, wr_dbh with data_out=0x00 the cycle after. busy=1 throughout. After the 2nd en_16x pulse: done pulse, cur_div=0x001A, locked=1. With a live BRG, en_16x then has a 27-cycle period.
2. div_req with div_val=0x1234 -> strobes carry 0x34 then 0x12 on consecutive cycles; after 2 en_16x pulses, done and cur_div=0x1234.
3. sel_req sel_idx=6, and separately div_req with div_val=0 -> err pulse 1 cycle after the request, no strobes, busy stays 0, cur_div=0x0145.
4. div_req(0x0050) and sel_req(0) in the same cycle -> data_out bytes 0x50 then 0x00; cur_div=0x0050. A second sel_req issued while busy is dropped.
5. Hold en_16x low after WR_HI -> err exactly TIMEOUT+1 cycles after entering SYNC, locked=0, cur_div unchanged. A subsequent valid request completes normally.
6. Assert rst_n low during SYNC -> all outputs at reset values in the same cycle (async); after release, state is IDLE and cur_div=0x0145.

Source files
------------

// File: rtl/brg_cfg_ctrl.sv
// BRG divisor configuration sequencer: writes the divisor low byte then high byte,
// then waits for two en_16x reloads to confirm the new rate before reporting done/err.
module brg_cfg_ctrl #(
  parameter int unsigned TIMEOUT = 140000,
  parameter int unsigned TO_W    = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_req,
  input  logic [2:0]  sel_idx,
  input  logic        div_req,
  input  logic [15:0] div_val,
  input  logic        en_16x,
  output logic        wr_dbl,
  output logic        wr_dbh,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        locked,
  output logic [15:0] cur_div
);

  localparam int unsigned DIV_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PC_W = 2;
  localparam logic [DIV_W-1:0] RST_DIV = 16'h0145;

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, SYNC} state_t;

  state_t              state, state_n;
  logic [DIV_W-1:0]    pend_div, pend_div_n, tgt_div, cur_div_n;
  logic [PC_W-1:0]     pcnt, pcnt_n;
  logic [TO_W-1:0]     tcnt, tcnt_n;
  logic [BYTE_W-1:0]   data_n;
  logic                wr_dbl_n, wr_dbh_n, busy_n, done_n, err_n, locked_n;
  logic                req, req_bad, sync_ok, sync_to;

  // Request decode: div_req wins over sel_req; table holds 50 MHz divisors
  always_comb begin
    tgt_div = '0;
    req_bad = 1'b0;
    req     = div_req | sel_req;
    if (div_req) begin
      tgt_div = div_val;
      req_bad = (div_val == '0);
    end else if (sel_req) begin
      case (sel_idx)
        3'd0:    tgt_div = 16'h028A;
        3'd1:    tgt_div = 16'h0145;
        3'd2:    tgt_div = 16'h00A2;
        3'd3:    tgt_div = 16'h0050;
        3'd4:    tgt_div = 16'h0035;
        3'd5:    tgt_div = 16'h001A;
        default: req_bad = 1'b1;
      endcase
    end
  end

  // Second reload pulse confirms the new period; it beats a simultaneous timeout
  assign sync_ok = en_16x && (pcnt == PC_W'(1));
  assign sync_to = (tcnt == TO_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_dbl   <= 1'b0;
      wr_dbh   <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      locked   <= 1'b1;
      cur_div  <= RST_DIV;
      pend_div <= RST_DIV;
      pcnt     <= '0;
      tcnt     <= '0;
    end else begin
      state    <= state_n;
      wr_dbl   <= wr_dbl_n;
      wr_dbh   <= wr_dbh_n;
      data_out <= data_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      locked   <= locked_n;
      cur_div  <= cur_div_n;
      pend_div <= pend_div_n;
      pcnt     <= pcnt_n;
      tcnt     <= tcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req && !req_bad) state_n = WR_LO;
      WR_LO:   state_n = WR_HI;
      WR_HI:   state_n = SYNC;
      SYNC:    if (sync_ok || sync_to) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values for the registered outputs and counters
  always_comb begin
    wr_dbl_n   = 1'b0;
    wr_dbh_n   = 1'b0;
    data_n     = '0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    locked_n   = locked;
    cur_div_n  = cur_div;
    pend_div_n = pend_div;
    pcnt_n     = pcnt;
    tcnt_n     = tcnt;
    busy_n     = (state_n != IDLE);
    case (state)
      IDLE: begin
        if (req) begin
          if (req_bad) begin
            err_n = 1'b1;
          end else begin
            pend_div_n = tgt_div;
            locked_n   = 1'b0;
            wr_dbl_n   = 1'b1;
            data_n     = tgt_div[BYTE_W-1:0];
          end
        end
      end
      WR_LO: begin
        wr_dbh_n = 1'b1;
        data_n   = pend_div[DIV_W-1:BYTE_W];
      end
      WR_HI: begin
        pcnt_n = '0;
        tcnt_n = '0;
      end
      SYNC: begin
        if (en_16x) pcnt_n = pcnt + PC_W'(1);
        if (!sync_to) tcnt_n = tcnt + TO_W'(1);
        if (sync_ok) begin
          done_n    = 1'b1;
          cur_div_n = pend_div;
          locked_n  = 1'b1;
        end else if (sync_to) begin
          err_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
